// File: rtl/primogen_arb_pkg.sv
// Shared types and helpers for the primogen round-robin arbiter.
package primogen_arb_pkg;

  // Arbiter states; RECOVER is only reachable when PRIMOGEN_ARB_TIMEOUT_EN is defined.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GUARD   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

  // Prime width derived from its log2, matching primogen's WIDTH_LOG.
  function automatic int width_of(input int log);
    return 1 << log;
  endfunction

endpackage

// File: rtl/primogen_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_picker
  import primogen_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    win,
  output logic             any
);

  // Requests duplicated so a cyclic search becomes a plain linear window scan.
  logic [2*N_REQ-1:0] dbl;
  assign dbl = {req, req};

  // Scan downward so the lowest index inside [ptr, ptr+N_REQ) wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (i >= int'(ptr) && i < int'(ptr) + N_REQ && dbl[i]) begin
        any = 1'b1;
        win = (i >= N_REQ) ? PW'(i - N_REQ) : PW'(i);
      end
    end
  end

endmodule

// File: rtl/primogen_arbiter.sv
// Round-robin arbiter sharing one primogen between N_REQ clients.
// Optional watchdog: define PRIMOGEN_ARB_TIMEOUT_EN to reset a stuck primogen
// after TIMEOUT_CYCLES cycles in WAIT.
module primogen_arbiter
  import primogen_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH_LOG      = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [width_of(WIDTH_LOG)-1:0]  rsp_data,
  output logic                            rsp_err,
  output logic                            pg_go,
  output logic                            pg_rst,
  input  logic                            pg_ready,
  input  logic                            pg_error,
  input  logic [width_of(WIDTH_LOG)-1:0]  pg_res,
  output logic                            busy
);

  localparam int W  = width_of(WIDTH_LOG);
  localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  // Reject configurations outside the supported range at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("primogen_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             pg_go_q, pg_go_d;
  logic [PW-1:0]    win;
  logic             any;
  logic             wd_fire;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign wd_fire = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES));
`else
  assign wd_fire = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pg_go_d     = 1'b0;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pg_ready && any) begin
          rsp_valid_d = N_REQ'(1) << win;
          ptr_d       = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          if (pg_error) begin
            // Overflowed generator: answer with an error, never advance it.
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            rsp_err_d  = 1'b0;
            rsp_data_d = pg_res;
            pg_go_d    = 1'b1;
            state_d    = GUARD;
          end
        end
      end
      GUARD: begin
        // primogen sees go one clock late, so pg_ready is still stale here.
        state_d = WAIT;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (pg_ready) begin
          state_d = IDLE;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        end else if (wd_fire) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RECOVER: begin
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
        if (pg_ready) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      pg_go_q     <= 1'b0;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      pg_go_q     <= pg_go_d;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign pg_go     = pg_go_q;
  assign pg_rst    = rst | wd_fire;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_primogen_arbiter.sv
// Directed bench for primogen_arbiter with a behavioural primogen stand-in.
module tb_primogen_arbiter;

  localparam int N     = 4;
  localparam int DELAY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        pg_go;
  logic        pg_rst;
  logic        pg_ready;
  logic        pg_error = 1'b0;
  logic [15:0] pg_res;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  primogen_arbiter #(
    .N_REQ          (N),
    .WIDTH_LOG      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .pg_go     (pg_go),
    .pg_rst    (pg_rst),
    .pg_ready  (pg_ready),
    .pg_error  (pg_error),
    .pg_res    (pg_res),
    .busy      (busy)
  );

  // Behavioural primogen: ready drops the edge after go, returns DELAY+1 cycles later.
  logic [15:0] primes [12] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13,
                               16'd17, 16'd19, 16'd23, 16'd29, 16'd31, 16'd37};
  int   pidx = 0;
  int   m_cnt = 0;
  logic m_ready = 1'b1;
  logic hold_ready = 1'b0;
  logic stall = 1'b0;

  always @(posedge clk) begin
    if (pg_rst) begin
      pidx    <= 0;
      m_ready <= 1'b1;
      m_cnt   <= 0;
    end else if (pg_go) begin
      pidx    <= (pidx + 1) % 12;
      m_ready <= hold_ready;
      m_cnt   <= DELAY;
    end else if (!m_ready && !stall) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else            m_cnt   <= m_cnt - 1;
    end
  end

  assign pg_ready = m_ready;
  assign pg_res   = primes[pidx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int budget, output logic found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && pg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        err;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_go;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic found;
    int   last_t;
    int   t;
    logic [15:0] seq_data [8];

    // Ptr and prime index evolve across rows; each expectation accounts for them.
    vecs[0] = '{4'b0100, 1'b0, 4'b0100, 16'd2,  1'b0, 1'b1, 1'b1};
    vecs[1] = '{4'b0011, 1'b0, 4'b0001, 16'd3,  1'b0, 1'b1, 1'b1};
    vecs[2] = '{4'b0011, 1'b0, 4'b0010, 16'd5,  1'b0, 1'b1, 1'b1};
    vecs[3] = '{4'b1001, 1'b0, 4'b1000, 16'd7,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{4'b0010, 1'b1, 4'b0010, 16'd0,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b1010, 1'b0, 4'b1000, 16'd11, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'b1000, 1'b0, 4'b1000, 16'd13, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'b0110, 1'b0, 4'b0010, 16'd17, 1'b0, 1'b1, 1'b1};
    seq_data = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19};

    // Reset state with every client requesting.
    req = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_valid",  32'(rsp_valid), 32'd0);
    chk("rst_go",     32'(pg_go),     32'd0);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_data",   32'(rsp_data),  32'd0);
    chk("rst_err",    32'(rsp_err),   32'd0);
    chk("rst_pg_rst", 32'(pg_rst),    32'd1);
    req = '0;
    rst = 1'b0;
    #1 chk("pg_rst_low", 32'(pg_rst), 32'd0);

    // Table-driven single grants.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req      = vecs[v].req;
      pg_error = vecs[v].err;
      wait_rsp(30, found);
      if (!found) begin
        chk($sformatf("v%0d_timeout", v), 32'd0, 32'd1);
      end else begin
        chk($sformatf("v%0d_valid", v), 32'(rsp_valid), 32'(vecs[v].exp_valid));
        chk($sformatf("v%0d_data", v),  32'(rsp_data),  32'(vecs[v].exp_data));
        chk($sformatf("v%0d_err", v),   32'(rsp_err),   32'(vecs[v].exp_err));
        chk($sformatf("v%0d_go", v),    32'(pg_go),     32'(vecs[v].exp_go));
        chk($sformatf("v%0d_busy", v),  32'(busy),      32'(vecs[v].exp_busy));
      end
      req      = '0;
      pg_error = 1'b0;
      wait_idle();
    end

    // Reset while in WAIT: grant is aborted, ptr returns to 0.
    @(negedge clk);
    req = 4'b0100;
    wait_rsp(30, found);
    chk("rw_found", 32'(found),     32'd1);
    chk("rw_valid", 32'(rsp_valid), 32'b0100);
    chk("rw_data",  32'(rsp_data),  32'd19);
    req = 4'b1010;
    @(negedge clk);
    chk("rw_in_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 chk("rw_pg_rst", 32'(pg_rst), 32'd1);
    @(negedge clk);
    chk("rw_valid0", 32'(rsp_valid), 32'd0);
    chk("rw_go0",    32'(pg_go),     32'd0);
    chk("rw_busy0",  32'(busy),      32'd0);
    chk("rw_data0",  32'(rsp_data),  32'd0);
    chk("rw_err0",   32'(rsp_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_next_valid", 32'(rsp_valid), 32'b0010);
    chk("rw_next_data",  32'(rsp_data),  32'd2);
    req = '0;
    wait_idle();

    // Eight grants with all clients requesting continuously.
    pulse_rst();
    req = 4'hF;
    for (int g = 0; g < 8; g++) begin
      wait_rsp(40, found);
      if (!found) begin
        chk($sformatf("seq%0d_timeout", g), 32'd0, 32'd1);
        break;
      end
      chk($sformatf("seq%0d_valid", g), 32'(rsp_valid), 32'd1 << (g % 4));
      chk($sformatf("seq%0d_data", g),  32'(rsp_data),  32'(seq_data[g]));
      chk($sformatf("seq%0d_go", g),    32'(pg_go),     32'd1);
    end
    req = '0;
    wait_idle();

    // pg_ready never drops: GUARD must still enforce 3-cycle spacing.
    hold_ready = 1'b1;
    req        = 4'hF;
    t          = 0;
    last_t     = -1;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        t++;
        if (rsp_valid != '0) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        chk("guard_timeout", 32'd0, 32'd1);
        break;
      end
      if (last_t >= 0) chk($sformatf("guard_spacing%0d", g), 32'(t - last_t), 32'd3);
      last_t = t;
    end
    req        = '0;
    hold_ready = 1'b0;
    wait_idle();

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    // Stuck primogen: watchdog pulses pg_rst 16 cycles into WAIT, then recovers.
    pulse_rst();
    stall = 1'b1;
    req   = 4'b0001;
    wait_rsp(30, found);
    chk("to_grant", 32'(rsp_valid), 32'b0001);
    req   = '0;
    found = 1'b0;
    t     = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (pg_rst) begin
        found = 1'b1;
        t     = k;
        break;
      end
    end
    chk("to_fired", 32'(found), 32'd1);
    chk("to_delay", 32'(t),     32'd17);
    @(negedge clk);
    chk("to_pulse_width", 32'(pg_rst), 32'd0);
    chk("to_recover_busy", 32'(busy),  32'd1);
    stall = 1'b0;
    @(negedge clk);
    chk("to_idle", 32'(busy), 32'd0);
    req = 4'b0010;
    wait_rsp(30, found);
    chk("to_restart_valid", 32'(rsp_valid), 32'b0010);
    chk("to_restart_data",  32'(rsp_data),  32'd2);
    req = '0;
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/primogen_arbiter.md
# primogen_arbiter

Round-robin arbiter sharing one `primogen` instance between `N_REQ` requesters. Each granted request returns the prime currently held by `primogen`, then the arbiter pulses `go` to advance it. Clients therefore receive successive primes in grant order. The block sits between `primogen` and board-level consumers, such as an LED display tick and a UART dumper, and replaces ad-hoc `go` pulsing in top-level modules.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH_LOG`, default 4: prime width `W = 1 << WIDTH_LOG`; must match `primogen`.
- `TIMEOUT_CYCLES`, default 2**20: watchdog limit; used only with `PRIMOGEN_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  `N_REQ`  per-client level request.
- `rsp_valid`  out  `N_REQ`  one-hot, one-cycle response pulse.
- `rsp_data`  out  `W`  prime returned; valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  qualifies `rsp_valid`: 1 means no prime was delivered.
- `pg_go`  out  1  one-cycle advance pulse to `primogen`.
- `pg_rst`  out  1  reset to `primogen`: `rst` ORed with the watchdog reset pulse.
- `pg_ready`  in  1  `primogen` ready.
- `pg_error`  in  1  `primogen` overflow, sticky.
- `pg_res`  in  `W`  current prime.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, GUARD, WAIT, and RECOVER (RECOVER exists only with `PRIMOGEN_ARB_TIMEOUT_EN`).
- **IDLE:**
  - `req` is sampled only in IDLE.
  - With `pg_ready` high and `|req` high, the winner is the first set bit at or after `ptr`, searching upward cyclically.
  - If `pg_error` is 0: `rsp_valid[win]`<=1, `rsp_data`<=`pg_res`, `rsp_err`<=0, `pg_go`<=1, then go to GUARD.
  - If `pg_error` is 1: `rsp_valid[win]`<=1, `rsp_err`<=1, `rsp_data`<=0, no `pg_go`, stay in IDLE.
  - In both cases `ptr`<=(`win`+1) mod `N_REQ`.
- **GUARD:** lasts exactly one cycle and ignores `pg_ready`, because `primogen` registers `go` one clock late. Then go to WAIT.
- **WAIT:** when `pg_ready`=1, go to IDLE.
- **Client protocol:**
  - A client holds `req` until it sees its `rsp_valid` bit, then drops `req` the next cycle.
  - A request still high in IDLE after its response is treated as a new request.
  - Dropping `req` before a grant withdraws the request with no response.
- **Fairness:** `ptr` resets to 0. With all clients requesting continuously, grants go 0,1,...,N_REQ-1,0,...
- **Reset mid-operation:** `rst` in any state returns to IDLE the next cycle.
  - `rsp_valid`, `pg_go`, and `ptr` are cleared.
  - `pg_rst` follows `rst` combinationally.
  - No response is issued for the aborted grant.
- **Reset values:** `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `pg_go`=0, `busy`=0, state IDLE, `ptr`=0.

## Timing
- **Grant latency:** `rsp_valid` is asserted one cycle after a cycle in IDLE with `pg_ready` and `req` both high.
- **`pg_go`:** asserted in the same cycle as `rsp_valid`.
- **Grant spacing:** minimum 3 cycles (grant, GUARD, at least one WAIT cycle); actual spacing is set by the `primogen` search time.
- **Output registers:** `rsp_valid`, `rsp_data`, `rsp_err`, and `pg_go` are all registered, with no combinational path from `req`.
- **Simultaneous `rst` and grant condition:** reset wins.

## Configuration
- **`PRIMOGEN_ARB_TIMEOUT_EN` defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in WAIT.
  - When it reaches `TIMEOUT_CYCLES`: assert `pg_rst` for exactly 1 cycle, enter RECOVER, and wait for `pg_ready`, then return to IDLE.
  - After recovery `primogen` restarts from its initial prime.
  - The timed-out grant has already been answered, so no extra response is issued.
  - The counter clears on entry to WAIT.
- **Undefined:** WAIT waits indefinitely; `pg_rst` equals `rst`; no RECOVER state and no counter logic.

## Structure
- **Package `primogen_arb_pkg`:** state enum (IDLE, GUARD, WAIT, RECOVER) and a `width_of(log)` constant function.
- **Sub-module `rr_picker`:** combinational; inputs `req[N_REQ]` and `ptr`; outputs `win` index and `any`. Implemented as a double-width priority scan.
- All sequential logic lives in `primogen_arbiter`.

## Test plan
- After reset, single client 2 requests with `pg_res`=2 → `rsp_valid`=4'b0100, `rsp_data`=2, one `pg_go` pulse, `busy` high until `pg_ready` returns.
- All 4 clients request continuously through 8 grants with a real `primogen` → `rsp_valid` order 0,1,2,3,0,1,2,3 with `rsp_data` 2,3,5,7,11,13,17,19.
- `pg_ready` held high during GUARD → no second grant until WAIT observes `pg_ready`; grant spacing ≥3 cycles.
- `pg_error`=1 with a request from client 1 → `rsp_valid[1]` pulse with `rsp_err`=1, `rsp_data`=0, no `pg_go`.
- `rst` asserted in WAIT → next cycle all outputs are at reset values and `ptr`=0; the next grant goes to the lowest requester.
- With `PRIMOGEN_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `pg_ready` held low after a grant → 1-cycle `pg_rst` pulse exactly 16 cycles into WAIT, then RECOVER, then IDLE once `pg_ready` rises.
